tile_rasterizer: RTL

TILE_RASTERIZER -- requirements
Module: tile_rasterizer

---
 rtl/tile_rasterizer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_rasterizer.sv
// Tile rasterizer: scans a triangle's clamped bounding box with CORES_COUNT row lanes and
// emits per-lane framebuffer writes. Optional macro RASTER_EDGE_INCLUSIVE_EN draws edge pixels.
module tile_rasterizer #(
    parameter int COORD_WIDTH   = 16,
    parameter int COLOR_WIDTH   = 16,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            eoc,
    input  logic [COORD_WIDTH-1:0]          bbox_min_x,
    input  logic [COORD_WIDTH-1:0]          bbox_min_y,
    input  logic [COORD_WIDTH-1:0]          bbox_max_x,
    input  logic [COORD_WIDTH-1:0]          bbox_max_y,
    input  logic signed [COORD_WIDTH-1:0]   bound_coefs [3][2],
    input  logic signed [2*COORD_WIDTH-1:0] bound_const [3],
    input  logic [COLOR_WIDTH-1:0]          color,
    input  logic [BUFFER_ADDR_W-1:0]        fb_base,
    output logic [COLOR_WIDTH-1:0]          ppu_data    [CORES_COUNT],
    output logic [BUFFER_ADDR_W-1:0]        ppu_address [CORES_COUNT],
    output logic                            ppu_valid   [CORES_COUNT],
    input  logic                            ppu_ready   [CORES_COUNT]
);

    localparam int EW = 2*COORD_WIDTH + 2;
    localparam int YW = COORD_WIDTH + 1;
    localparam logic [COORD_WIDTH-1:0]   X_LAST  = COORD_WIDTH'(SCREEN_X_SIZE - 1);
    localparam logic [COORD_WIDTH-1:0]   Y_LAST  = COORD_WIDTH'(SCREEN_Y_SIZE - 1);
    localparam logic [YW-1:0]            LANES_Y = YW'(CORES_COUNT);
    localparam logic [BUFFER_ADDR_W-1:0] SX_A    = BUFFER_ADDR_W'(SCREEN_X_SIZE);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic                        eoc_q, eoc_d;
    logic [COORD_WIDTH-1:0]      min_x_q, min_x_d, max_x_q, max_x_d;
    logic [COORD_WIDTH-1:0]      min_y_q, min_y_d, max_y_q, max_y_d;
    logic signed [COORD_WIDTH-1:0]   a_q [3], a_d [3], b_q [3], b_d [3];
    logic signed [2*COORD_WIDTH-1:0] c_q [3], c_d [3];
    logic signed [EW-1:0]        bstep_q [3], bstep_d [3];
    logic [COLOR_WIDTH-1:0]      color_q, color_d;
    logic [BUFFER_ADDR_W-1:0]    fb_base_q, fb_base_d;
    logic [COORD_WIDTH-1:0]      x_q, x_d;
    logic [YW-1:0]               row_q, row_d;
    logic signed [EW-1:0]        e_cur_q [CORES_COUNT][3], e_cur_d [CORES_COUNT][3];
    logic signed [EW-1:0]        e_row_q [CORES_COUNT][3], e_row_d [CORES_COUNT][3];
    logic                        valid_q [CORES_COUNT], valid_d [CORES_COUNT];
    logic [COLOR_WIDTH-1:0]      data_q  [CORES_COUNT], data_d  [CORES_COUNT];
    logic [BUFFER_ADDR_W-1:0]    addr_q  [CORES_COUNT], addr_d  [CORES_COUNT];

    logic [YW-1:0]               lane_y    [CORES_COUNT];
    logic                        lane_in   [CORES_COUNT];
    logic [BUFFER_ADDR_W-1:0]    lane_addr [CORES_COUNT];
    logic                        stall;

    function automatic logic edge_inside(input logic signed [EW-1:0] e0, e1, e2);
        logic [2:0] pos;
        logic [2:0] neg;
`ifdef RASTER_EDGE_INCLUSIVE_EN
        pos = {~e2[EW-1], ~e1[EW-1], ~e0[EW-1]};
        neg = {e2[EW-1] | (e2 == 0), e1[EW-1] | (e1 == 0), e0[EW-1] | (e0 == 0)};
`else
        pos = {~e2[EW-1] & (e2 != 0), ~e1[EW-1] & (e1 != 0), ~e0[EW-1] & (e0 != 0)};
        neg = {e2[EW-1], e1[EW-1], e0[EW-1]};
`endif
        return (&pos) | (&neg);
    endfunction

    // Per-lane evaluation of the current scan position.
    always_comb begin
        for (int k = 0; k < CORES_COUNT; k++) begin
            lane_y[k]    = row_q + YW'(k);
            lane_in[k]   = (lane_y[k] <= {1'b0, max_y_q}) &&
                           edge_inside(e_cur_q[k][0], e_cur_q[k][1], e_cur_q[k][2]);
            lane_addr[k] = fb_base_q + BUFFER_ADDR_W'(lane_y[k]) * SX_A + BUFFER_ADDR_W'(x_q);
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < CORES_COUNT; k++) begin
            stall = stall | (valid_q[k] & ~ppu_ready[k]);
        end
    end

    always_comb begin
        state_d   = state_q;
        eoc_d     = 1'b0;
        min_x_d   = min_x_q;
        max_x_d   = max_x_q;
        min_y_d   = min_y_q;
        max_y_d   = max_y_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        bstep_d   = bstep_q;
        color_d   = color_q;
        fb_base_d = fb_base_q;
        x_d       = x_q;
        row_d     = row_q;
        e_cur_d   = e_cur_q;
        e_row_d   = e_row_q;
        data_d    = data_q;
        addr_d    = addr_q;
        // Without a stall every pending write leaves this cycle; otherwise only
        // the accepted lanes drop valid and everything else holds.
        for (int k = 0; k < CORES_COUNT; k++) begin
            valid_d[k] = stall ? (valid_q[k] & ~ppu_ready[k]) : 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !eoc_q) begin
                    min_x_d   = bbox_min_x;
                    min_y_d   = bbox_min_y;
                    max_x_d   = (bbox_max_x > X_LAST) ? X_LAST : bbox_max_x;
                    max_y_d   = (bbox_max_y > Y_LAST) ? Y_LAST : bbox_max_y;
                    for (int i = 0; i < 3; i++) begin
                        a_d[i] = bound_coefs[i][0];
                        b_d[i] = bound_coefs[i][1];
                        c_d[i] = bound_const[i];
                    end
                    color_d   = color;
                    fb_base_d = fb_base;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                for (int i = 0; i < 3; i++) begin
                    bstep_d[i] = EW'(b_q[i]) * EW'(CORES_COUNT);
                    for (int k = 0; k < CORES_COUNT; k++) begin
                        e_row_d[k][i] = EW'(a_q[i]) * $signed(EW'({1'b0, min_x_q}))
                                      + EW'(b_q[i]) * ($signed(EW'({1'b0, min_y_q})) + EW'(k))
                                      + EW'(c_q[i]);
                        e_cur_d[k][i] = e_row_d[k][i];
                    end
                end
                x_d     = min_x_q;
                row_d   = {1'b0, min_y_q};
                state_d = ((min_x_q > max_x_q) || (min_y_q > max_y_q)) ? DRAIN : SCAN;
            end
            SCAN: begin
                if (!stall) begin
                    for (int k = 0; k < CORES_COUNT; k++) begin
                        valid_d[k] = lane_in[k];
                        data_d[k]  = color_q;
                        addr_d[k]  = lane_addr[k];
                    end
                    if (x_q == max_x_q) begin
                        x_d   = min_x_q;
                        row_d = row_q + LANES_Y;
                        for (int k = 0; k < CORES_COUNT; k++) begin
                            for (int i = 0; i < 3; i++) begin
                                e_row_d[k][i] = e_row_q[k][i] + bstep_q[i];
                                e_cur_d[k][i] = e_row_q[k][i] + bstep_q[i];
                            end
                        end
                        if (row_q + LANES_Y > {1'b0, max_y_q}) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = x_q + COORD_WIDTH'(1);
                        for (int k = 0; k < CORES_COUNT; k++) begin
                            for (int i = 0; i < 3; i++) begin
                                e_cur_d[k][i] = e_cur_q[k][i] + EW'(a_q[i]);
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    eoc_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            eoc_q   <= 1'b0;
            for (int k = 0; k < CORES_COUNT; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                addr_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Triangle and scan datapath needs no reset: it is always reloaded before use.
    always_ff @(posedge clk) begin
        min_x_q   <= min_x_d;
        max_x_q   <= max_x_d;
        min_y_q   <= min_y_d;
        max_y_q   <= max_y_d;
        a_q       <= a_d;
        b_q       <= b_d;
        c_q       <= c_d;
        bstep_q   <= bstep_d;
        color_q   <= color_d;
        fb_base_q <= fb_base_d;
        x_q       <= x_d;
        row_q     <= row_d;
        e_cur_q   <= e_cur_d;
        e_row_q   <= e_row_d;
    end

    assign busy        = (state_q != IDLE) || eoc_q;
    assign eoc         = eoc_q;
    assign ppu_valid   = valid_q;
    assign ppu_data    = data_q;
    assign ppu_address = addr_q;

endmodule
